fifo_ser_tx: RTL and testbench

FIFO_SER_TX -- requirements
Module: fifo_ser_tx

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ser_tx_baud.sv | 27 ++
 rtl/fifo_ser_tx.sv | 98 +++++++++
 tb/tb_fifo_ser_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO-fed serial transmitter.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DWID_DEFAULT = 16;

endpackage

// File: rtl/fifo_ser_tx_baud.sv
// Bit-period timer: tick marks the last clk cycle of each serial bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == CW'(CLKS_PER_BIT - 1));

  // Reloading on tick keeps every bit exactly CLKS_PER_BIT cycles long.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/fifo_ser_tx.sv
// Pops words from a first-word-fall-through FIFO and sends each as a
// start bit, DWID data bits LSB first, and a stop bit.
module fifo_ser_tx
  import fifo_pkg::*;
#(
  parameter int DWID         = DWID_DEFAULT,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            empty_i,
  input  logic [DWID-1:0] rdata_i,
  output logic            rd_o,
  output logic            tx_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int BW = $clog2(DWID);

  tx_state_t       state, state_nxt;
  logic [DWID-1:0] shreg, shreg_nxt;
  logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
  logic            tx_nxt;
  logic            tick;

  // Holding the timer clear in IDLE restarts it on the capture edge.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_o    <= tx_nxt;
    end
  end

  // tx_nxt is the line value for the following cycle, so tx_o is a pure flop.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx_o;
    rd_o        = (state == IDLE) && en_i && !empty_i && rst;
    busy_o      = (state != IDLE);
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_o) begin
          state_nxt   = START;
          shreg_nxt   = rdata_i;
          bit_cnt_nxt = '0;
          tx_nxt      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == BW'(DWID - 1)) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            shreg_nxt   = shreg >> 1;
            tx_nxt      = shreg[1];
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          done_o    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Directed bench for fifo_ser_tx at DWID=16, CLKS_PER_BIT=4.
module tb_fifo_ser_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        empty_i;
  logic [15:0] rdata_i;
  logic        rd_o;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  int vec_count  = 0;
  int fail_count = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        empty;
    logic [15:0] data;
    logic        exp_rd;
    logic        exp_tx;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[5];

  fifo_ser_tx #(
    .DWID        (16),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .empty_i(empty_i),
    .rdata_i(rdata_i),
    .rd_o   (rd_o),
    .tx_o   (tx_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic act, input logic exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %b, wanted %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic em, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst     = r;
    en_i    = e;
    empty_i = em;
    rdata_i = d;
  endtask

  // Expected line value k cycles after the capture edge.
  function automatic logic exp_line(input int k, input logic [15:0] w);
    if (k <= 4) return 1'b0;
    if (k <= 68) return w[(k - 5) / 4];
    return 1'b1;
  endfunction

  // Runs one frame through cycle 73. If prepopped, the pop cycle already happened.
  task automatic run_frame(input logic [15:0] word, input logic prepopped,
                           input logic more, input logic [15:0] next_word,
                           input logic scramble, input int en_drop_k);
    if (!prepopped) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, word);
      @(negedge clk);
      check_output("pop_rd", rd_o, 1'b1);
      check_output("pop_busy", busy_o, 1'b0);
    end
    for (int k = 1; k <= 73; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        empty_i = !more;
        if (more) rdata_i = next_word;
      end else if (scramble) begin
        rdata_i = 16'($urandom);
      end
      if (k == en_drop_k) en_i = 1'b0;
      @(negedge clk);
      check_output($sformatf("tx_k%0d", k), tx_o, exp_line(k, word));
      check_output($sformatf("busy_k%0d", k), busy_o, k <= 72);
      check_output($sformatf("done_k%0d", k), done_o, k == 72);
      check_output($sformatf("rd_k%0d", k), rd_o, (k == 73) && more && (en_drop_k == 0));
    end
  endtask

  initial begin
    rst = 1'b0; en_i = 1'b0; empty_i = 1'b1; rdata_i = 16'h0000;

    vecs[0] = '{"reset_hold",   1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"reset_hold2",  1'b0, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"en_low",       1'b1, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"empty_hi",     1'b1, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"both_off",     1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].empty, vecs[i].data);
      @(negedge clk);
      check_output({vecs[i].name, "_rd"},   rd_o,   vecs[i].exp_rd);
      check_output({vecs[i].name, "_tx"},   tx_o,   vecs[i].exp_tx);
      check_output({vecs[i].name, "_busy"}, busy_o, vecs[i].exp_busy);
      check_output({vecs[i].name, "_done"}, done_o, vecs[i].exp_done);
    end

    $display("[TB] empty FIFO with enable high");
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, 16'hDEAD);
      @(negedge clk);
      check_output("idle_rd", rd_o, 1'b0);
      check_output("idle_tx", tx_o, 1'b1);
      check_output("idle_busy", busy_o, 1'b0);
    end

    $display("[TB] single word A5C3");
    run_frame(16'hA5C3, 1'b0, 1'b0, 16'h0000, 1'b0, 0);

    $display("[TB] back-to-back 0001 then FFFF");
    run_frame(16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 0);
    run_frame(16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 0);

    $display("[TB] enable dropped mid-frame");
    run_frame(16'h5A0F, 1'b0, 1'b1, 16'h1234, 1'b0, 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("en_off_rd", rd_o, 1'b0);
      check_output("en_off_busy", busy_o, 1'b0);
    end
    run_frame(16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 0);

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'hC30F);
    @(negedge clk);
    check_output("abort_pop", rd_o, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) rdata_i = 16'h1357;
      if (k == 30) begin
        rst = 1'b0;
        #1;
        check_output("abort_tx", tx_o, 1'b1);
        check_output("abort_busy", busy_o, 1'b0);
        check_output("abort_rd", rd_o, 1'b0);
        check_output("abort_done", done_o, 1'b0);
      end else begin
        @(negedge clk);
        check_output("pre_abort_busy", busy_o, 1'b1);
        if (k == 29) check_output("pre_abort_tx", tx_o, 1'b0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("release_rd", rd_o, 1'b1);
    check_output("release_busy", busy_o, 1'b0);
    run_frame(16'h1357, 1'b1, 1'b0, 16'h0000, 1'b0, 0);

    $display("[TB] rdata scrambled during frame");
    run_frame(16'h6E29, 1'b0, 1'b0, 16'h0000, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
